cmdout_subqueue_writer: RTL and testbench

Multi-channel writer that drains the accelerator command-out AXI-Stream into the BRAM-backed CmdOutQueue, one ring subqueue per accelerator. Successor to the fixed single-port cmdout path: parametrised channel count, subqueue depth and BRAM read latency, with tlast-framed variable-length packets, slot-free polling and header-last publication. Sits between the accelerator interconnect and the host-visible CmdOutQueue BRAM port inside the OmpSs manager.

---
 rtl/cmdout_subqueue_writer.sv | 189 ++++++++++++++++++
 tb/tb_cmdout_subqueue_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdout_subqueue_writer.sv
// cmdout_subqueue_writer: drains the command-out AXI-Stream into one ring subqueue per
// accelerator inside the CmdOutQueue BRAM. Each slot is polled for free (valid byte 0x00)
// before it is used. The header slot is reserved first and written last, with its valid
// byte forced to 0x80, so the host only ever sees complete packets.
// Optional statistics counters are enabled by defining CMDOUT_WRITER_STATS_EN.
module cmdout_subqueue_writer #(
    parameter int unsigned MAX_ACCS     = 16,
    parameter int unsigned SUBQUEUE_LEN = 64,
    parameter int unsigned BRAM_LATENCY = 1
) (
    input  logic                        aclk,
    input  logic                        peripheral_aresetn,
    input  logic                        cmdout_in_tvalid,
    output logic                        cmdout_in_tready,
    input  logic [$clog2(MAX_ACCS)-1:0] cmdout_in_tid,
    input  logic [63:0]                 cmdout_in_tdata,
    input  logic                        cmdout_in_tlast,
    output logic                        cmdout_queue_clk,
    output logic                        cmdout_queue_rst,
    output logic                        cmdout_queue_en,
    output logic [7:0]                  cmdout_queue_we,
    output logic [31:0]                 cmdout_queue_addr,
    output logic [63:0]                 cmdout_queue_din,
    input  logic [63:0]                 cmdout_queue_dout,
    output logic                        error
`ifdef CMDOUT_WRITER_STATS_EN
    ,
    output logic [31:0]                 pkt_count,
    output logic [31:0]                 stall_count
`endif
);

    localparam int unsigned TidW = $clog2(MAX_ACCS);
    localparam int unsigned PtrW = $clog2(SUBQUEUE_LEN);

    typedef enum logic [2:0] {StIdle, StWait, StEval, StHdrWr, StDrain} state_e;

    state_e          state_q;
    logic [PtrW-1:0] wr_ptr_q [MAX_ACCS];
    logic [TidW-1:0] ch_q;
    logic            in_pkt_q;
    logic [PtrW:0]   cnt_q;
    logic [63:0]     hdr_q;
    logic [31:0]     hdr_addr_q;
    logic            ovf_q;

    logic            tid_bad;
    logic [TidW-1:0] ch_sel;
    logic [31:0]     slot_addr;
    logic            slot_free;
    logic [PtrW:0]   cnt_inc;

    // Only a header word carries a meaningful tid; later words use the latched channel.
    assign tid_bad   = !in_pkt_q && (32'(cmdout_in_tid) >= MAX_ACCS);
    assign ch_sel    = (state_q == StIdle && !in_pkt_q) ? cmdout_in_tid : ch_q;
    assign slot_addr = (32'(ch_sel) << (PtrW + 3)) | (32'(wr_ptr_q[ch_sel]) << 3);
    assign slot_free = (cmdout_queue_dout[63:56] == 8'h00);
    assign cnt_inc   = in_pkt_q ? cnt_q + 1'b1 : (PtrW + 1)'(1);

    assign cmdout_queue_clk = aclk;
    assign cmdout_queue_rst = ~peripheral_aresetn;

    // Packet sequencing: poll slot, accept word, publish header, drain bad/oversized packets.
    always_ff @(posedge aclk) begin
        if (!peripheral_aresetn) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            in_pkt_q   <= 1'b0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            hdr_addr_q <= '0;
            ovf_q      <= 1'b0;
            error      <= 1'b0;
            for (int i = 0; i < int'(MAX_ACCS); i++) begin
                wr_ptr_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmdout_in_tvalid) begin
                        if (tid_bad) begin
                            error   <= 1'b1;
                            state_q <= StDrain;
                        end else begin
                            if (!in_pkt_q) begin
                                ch_q <= cmdout_in_tid;
                            end
                            state_q <= (BRAM_LATENCY > 1) ? StWait : StEval;
                        end
                    end
                end
                StWait: state_q <= StEval;
                StEval: begin
                    if (!slot_free) begin
                        state_q <= StIdle;
                    end else begin
                        wr_ptr_q[ch_q] <= wr_ptr_q[ch_q] + 1'b1;
                        cnt_q          <= cnt_inc;
                        if (!in_pkt_q) begin
                            hdr_q      <= cmdout_in_tdata;
                            hdr_addr_q <= slot_addr;
                            in_pkt_q   <= 1'b1;
                        end
                        if (cmdout_in_tlast) begin
                            state_q <= StHdrWr;
                        end else if (cnt_inc == (PtrW + 1)'(SUBQUEUE_LEN)) begin
                            // Ring is exhausted: publish what fits, discard the rest.
                            error   <= 1'b1;
                            ovf_q   <= 1'b1;
                            state_q <= StHdrWr;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StHdrWr: begin
                    in_pkt_q <= 1'b0;
                    cnt_q    <= '0;
                    ovf_q    <= 1'b0;
                    state_q  <= ovf_q ? StDrain : StIdle;
                end
                StDrain: begin
                    if (cmdout_in_tvalid && cmdout_in_tlast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stream ready and BRAM port are decoded from state and the polled slot.
    always_comb begin
        cmdout_in_tready  = 1'b0;
        cmdout_queue_en   = 1'b0;
        cmdout_queue_we   = 8'h00;
        cmdout_queue_addr = '0;
        cmdout_queue_din  = '0;
        if (peripheral_aresetn) begin
            unique case (state_q)
                StIdle: begin
                    if (cmdout_in_tvalid && !tid_bad) begin
                        cmdout_queue_en   = 1'b1;
                        cmdout_queue_addr = slot_addr;
                    end
                end
                StWait: ;
                StEval: begin
                    if (slot_free) begin
                        cmdout_in_tready = 1'b1;
                        // Header is held back; body words go straight to their slot.
                        if (in_pkt_q) begin
                            cmdout_queue_en   = 1'b1;
                            cmdout_queue_we   = 8'hFF;
                            cmdout_queue_addr = slot_addr;
                            cmdout_queue_din  = cmdout_in_tdata;
                        end
                    end
                end
                StHdrWr: begin
                    cmdout_queue_en   = 1'b1;
                    cmdout_queue_we   = 8'hFF;
                    cmdout_queue_addr = hdr_addr_q;
                    cmdout_queue_din  = {8'h80, hdr_q[55:0]};
                end
                StDrain: cmdout_in_tready = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CMDOUT_WRITER_STATS_EN
    // Saturating counters of published packets and busy-slot polls.
    always_ff @(posedge aclk) begin
        if (!peripheral_aresetn) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (state_q == StHdrWr && pkt_count != '1) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (state_q == StEval && !slot_free && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmdout_subqueue_writer.sv
// Testbench for cmdout_subqueue_writer: behavioural BRAM with configurable read latency,
// a packet-level reference model of the subqueue rings, directed cases and random packets.
module tb_cmdout_subqueue_writer;

    localparam int unsigned MAX_ACCS     = 12;
    localparam int unsigned SUBQUEUE_LEN = 8;
    localparam int unsigned BRAM_LATENCY = 2;
    localparam int unsigned TID_W        = $clog2(MAX_ACCS);
    localparam int unsigned NSLOT        = MAX_ACCS * SUBQUEUE_LEN;

    logic             aclk = 1'b0;
    logic             peripheral_aresetn = 1'b0;
    logic             tvalid = 1'b0;
    logic             tready;
    logic [TID_W-1:0] tid = '0;
    logic [63:0]      tdata = '0;
    logic             tlast = 1'b0;
    logic             q_clk, q_rst, q_en;
    logic [7:0]       q_we;
    logic [31:0]      q_addr;
    logic [63:0]      q_din, q_dout;
    logic             error;

    logic [63:0]      mem   [NSLOT];
    logic [63:0]      model [NSLOT];
    int unsigned      exp_ptr [MAX_ACCS];
    logic             exp_err;
    logic [63:0]      rd1, rd2;
    logic [31:0]      wr_log [$];
    int unsigned      proto_err = 0;
    int unsigned      mon_idx;
    logic [63:0]      pkt [$];
    int               n_vec = 0;
    int               n_err = 0;

    cmdout_subqueue_writer #(
        .MAX_ACCS    (MAX_ACCS),
        .SUBQUEUE_LEN(SUBQUEUE_LEN),
        .BRAM_LATENCY(BRAM_LATENCY)
    ) dut (
        .aclk              (aclk),
        .peripheral_aresetn(peripheral_aresetn),
        .cmdout_in_tvalid  (tvalid),
        .cmdout_in_tready  (tready),
        .cmdout_in_tid     (tid),
        .cmdout_in_tdata   (tdata),
        .cmdout_in_tlast   (tlast),
        .cmdout_queue_clk  (q_clk),
        .cmdout_queue_rst  (q_rst),
        .cmdout_queue_en   (q_en),
        .cmdout_queue_we   (q_we),
        .cmdout_queue_addr (q_addr),
        .cmdout_queue_din  (q_din),
        .cmdout_queue_dout (q_dout),
        .error             (error)
    );

    always #5 aclk = ~aclk;

    // Read-first BRAM with BRAM_LATENCY output registers; logs every write address.
    always @(posedge aclk) begin
        if (q_en) begin
            mon_idx = q_addr >> 3;
            if (q_addr[2:0] != 3'b000 || mon_idx >= NSLOT) begin
                proto_err = proto_err + 1;
            end else begin
                rd1 <= mem[mon_idx];
                if (q_we == 8'hFF) begin
                    mem[mon_idx] = q_din;
                    wr_log.push_back(q_addr);
                end else if (q_we != 8'h00) begin
                    proto_err = proto_err + 1;
                end
            end
        end
        rd2 <= rd1;
    end
    assign q_dout = (BRAM_LATENCY == 2) ? rd2 : rd1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < int'(NSLOT); i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end
    endtask

    task automatic clear_ch(input int ch);
        for (int i = 0; i < int'(SUBQUEUE_LEN); i++) begin
            mem[ch * SUBQUEUE_LEN + i]   = '0;
            model[ch * SUBQUEUE_LEN + i] = '0;
        end
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < int'(NSLOT); i++) begin
            check_val($sformatf("%s slot %0d", tag, i), mem[i], model[i]);
        end
    endtask

    // Waits (bounded) for tready with tvalid up; returns #1 after the accepting edge.
    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Sends pkt[] on channel t and checks memory, write order and error against the model.
    task automatic run_pkt(input int t, input string tag);
        int          len = pkt.size();
        int          n   = 0;
        int          p   = 0;
        bit          ok;
        bit          bad = (t >= int'(MAX_ACCS));
        logic [31:0] hdr_a;
        if (bad) begin
            exp_err = 1'b1;
        end else begin
            p = int'(exp_ptr[t]);
            n = (len > int'(SUBQUEUE_LEN)) ? int'(SUBQUEUE_LEN) : len;
            for (int i = 1; i < n; i++) begin
                model[t * SUBQUEUE_LEN + (p + i) % SUBQUEUE_LEN] = pkt[i];
            end
            model[t * SUBQUEUE_LEN + p] = {8'h80, pkt[0][55:0]};
            exp_ptr[t] = (p + n) % SUBQUEUE_LEN;
            if (len > int'(SUBQUEUE_LEN)) exp_err = 1'b1;
        end
        hdr_a = 32'((t * int'(SUBQUEUE_LEN) + p) * 8);
        wr_log.delete();
        for (int i = 0; i < len; i++) begin
            tvalid = 1'b1;
            tid    = TID_W'(t);
            tdata  = pkt[i];
            tlast  = (i == len - 1);
            wait_hs(ok);
            if (!ok) begin
                check_val({tag, " handshake timeout"}, 64'(i), 64'(len));
                tvalid = 1'b0;
                tlast  = 1'b0;
                return;
            end
        end
        if (!bad && len <= int'(SUBQUEUE_LEN)) begin
            check_val({tag, " header publish cycle"}, 64'({q_en, q_we, q_addr}),
                      64'({1'b1, 8'hFF, hdr_a}));
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (4) @(negedge aclk);
        check_val({tag, " write count"}, 64'(wr_log.size()), 64'(n));
        if (n > 0 && wr_log.size() > 0) begin
            check_val({tag, " header written last"}, 64'(wr_log[wr_log.size() - 1]), 64'(hdr_a));
        end
        check_val({tag, " error"}, 64'(error), 64'(exp_err));
        compare_mem(tag);
    endtask

    // Holds a single-word packet against a busy slot, then the host frees that slot.
    task automatic stall_then_free(input int t, input logic [63:0] w, input int slot,
                                   input string tag);
        bit seen = 1'b0;
        wr_log.delete();
        tvalid = 1'b1;
        tid    = TID_W'(t);
        tdata  = w;
        tlast  = 1'b1;
        repeat (20) begin
            @(negedge aclk);
            if (tready) seen = 1'b1;
        end
        check_val({tag, " tready low while busy"}, 64'(seen), 64'd0);
        check_val({tag, " no write while busy"}, 64'(wr_log.size()), 64'd0);
        mem[slot]   = '0;
        model[slot] = '0;
        pkt.delete();
        pkt.push_back(w);
        run_pkt(t, tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        bit ok;
        int t;
        int len;
        logic [63:0] w [3];
        clear_all();
        foreach (exp_ptr[i]) exp_ptr[i] = 0;
        exp_err = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        check_val("reset tready", 64'(tready), 64'd0);
        check_val("reset en", 64'(q_en), 64'd0);
        check_val("reset we", 64'(q_we), 64'd0);
        check_val("reset error", 64'(error), 64'd0);
        check_val("reset queue_rst", 64'(q_rst), 64'd1);
        peripheral_aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_val("idle addr", 64'(q_addr), 64'd0);
        check_val("idle din", q_din, 64'd0);

        // Three-word packet on channel 3
        pkt = '{64'h11, 64'h22, 64'h33};
        run_pkt(3, "pkt3");

        // Busy header slot on channel 5
        mem[5 * SUBQUEUE_LEN]   = 64'h8000_0000_0000_0001;
        model[5 * SUBQUEUE_LEN] = 64'h8000_0000_0000_0001;
        stall_then_free(5, 64'h55, 5 * SUBQUEUE_LEN, "busy5");

        // Fill channel 0 with single-word packets, then wrap onto a busy slot 0
        for (int i = 0; i < int'(SUBQUEUE_LEN); i++) begin
            pkt.delete();
            pkt.push_back(64'h100 + 64'(i));
            run_pkt(0, $sformatf("fill0_%0d", i));
        end
        stall_then_free(0, 64'h0AA, 0, "wrap0");

        // Bad tid packet is drained with no BRAM write
        pkt = '{64'h1, 64'h2, 64'h3, 64'h4};
        run_pkt(13, "badtid");

        // Oversized packet: SUBQUEUE_LEN words stored, rest drained
        clear_ch(7);
        pkt.delete();
        for (int i = 0; i < int'(SUBQUEUE_LEN) + 3; i++) pkt.push_back(64'h7000 + 64'(i));
        run_pkt(7, "ovf7");

        // Reset mid-packet on channel 2
        for (int i = 0; i < 3; i++) w[i] = 64'hC200_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1;
            tid    = TID_W'(2);
            tdata  = w[i];
            tlast  = 1'b0;
            wait_hs(ok);
            if (!ok) check_val("partial handshake timeout", 64'(i), 64'd3);
        end
        tvalid = 1'b0;
        repeat (4) @(negedge aclk);
        check_val("partial body 1", mem[2 * SUBQUEUE_LEN + 1], w[1]);
        check_val("partial body 2", mem[2 * SUBQUEUE_LEN + 2], w[2]);
        check_val("partial header unpublished", mem[2 * SUBQUEUE_LEN], 64'd0);
        peripheral_aresetn = 1'b0;
        @(negedge aclk);
        check_val("midreset tready", 64'(tready), 64'd0);
        check_val("midreset en", 64'(q_en), 64'd0);
        check_val("midreset we", 64'(q_we), 64'd0);
        check_val("midreset addr", 64'(q_addr), 64'd0);
        check_val("midreset din", q_din, 64'd0);
        check_val("midreset error", 64'(error), 64'd0);
        @(negedge aclk);
        peripheral_aresetn = 1'b1;
        clear_all();
        foreach (exp_ptr[i]) exp_ptr[i] = 0;
        exp_err = 1'b0;
        pkt = '{64'hD1, 64'hD2};
        run_pkt(2, "postreset2");

        // Random packets; host consumes the target ring before each one
        for (int k = 0; k < 40; k++) begin
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_ACCS, 15))
                                            : int'($urandom_range(0, MAX_ACCS - 1));
            len = int'($urandom_range(1, SUBQUEUE_LEN + 3));
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(rnd64());
            if (t < int'(MAX_ACCS)) clear_ch(t);
            run_pkt(t, $sformatf("rnd%0d", k));
        end

        check_val("bram protocol errors", 64'(proto_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
